// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared MIPS decode constants: opcode/funct encodings, ERET word, exception bits, legal-instruction table.
package decode_ctrl_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [31:0] ERET_INSTR = 32'h4200_0018;

  localparam int EXC_SYS  = 0;
  localparam int EXC_BRK  = 1;
  localparam int EXC_ERET = 2;
  localparam int EXC_RI   = 3;

  typedef struct packed {
    logic ri;
    logic eret;
    logic brk;
    logic sys;
  } exc_t;

  // Native main-control vector layout; narrower/wider CTRL_W truncates/zero-pads it.
  localparam int CB_REG_WRITE  = 0;
  localparam int CB_REG_DST    = 1;
  localparam int CB_ALU_SRC    = 2;
  localparam int CB_MEM_READ   = 3;
  localparam int CB_MEM_WRITE  = 4;
  localparam int CB_MEM_TO_REG = 5;
  localparam int CB_BRANCH     = 6;
  localparam int CB_BRANCH_NE  = 7;
  localparam int CB_JUMP       = 8;
  localparam int CB_LINK       = 9;
  localparam int CB_IMM_ZEXT   = 10;
  localparam int CB_LUI        = 11;
  localparam int CTRL_BITS     = 12;

  localparam int ALU_BITS = 5;
  typedef enum logic [ALU_BITS-1:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_COP0, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic funct_legal(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_SYSCALL, FN_BREAK, FN_ADD, FN_ADDU,
      FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_field_decoder.sv
// Purpose: combinational MIPS decode of one instruction word into ctrl, aluop and exception bits.
// Latency: zero cycles, pure combinational.
// Backpressure: none; output follows instr every cycle.
module ctrl_field_decoder
  import decode_ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W  = 12,
  parameter int ALUOP_W = 5
) (
  input  logic [31:0]        instr,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [ALUOP_W-1:0] aluop,
  output exc_t               exc
);

  localparam int CN = (CTRL_W < CTRL_BITS) ? CTRL_W : CTRL_BITS;
  localparam int AN = (ALUOP_W < ALU_BITS) ? ALUOP_W : ALU_BITS;

  logic [5:0]           op;
  logic [5:0]           fn;
  logic [CTRL_BITS-1:0] c;
  alu_op_e              a;
  logic [ALU_BITS-1:0]  a_bits;

  assign op     = instr[31:26];
  assign fn     = instr[5:0];
  assign a_bits = a;

  always_comb begin
    c   = '0;
    a   = ALU_NONE;
    exc = '0;
    exc.sys  = (op == OP_RTYPE) && (fn == FN_SYSCALL);
    exc.brk  = (op == OP_RTYPE) && (fn == FN_BREAK);
    exc.eret = (instr == ERET_INSTR);
    // COP0 is only legal as the exact ERET word.
    exc.ri   = !op_legal(op) || ((op == OP_RTYPE) && !funct_legal(fn)) ||
               ((op == OP_COP0) && !exc.eret);
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_JR:                c[CB_JUMP] = 1'b1;
          FN_SYSCALL, FN_BREAK: c = '0;
          default: begin
            c[CB_REG_WRITE] = 1'b1;
            c[CB_REG_DST]   = 1'b1;
            case (fn)
              FN_ADD, FN_ADDU: a = ALU_ADD;
              FN_SUB, FN_SUBU: a = ALU_SUB;
              FN_AND:          a = ALU_AND;
              FN_OR:           a = ALU_OR;
              FN_XOR:          a = ALU_XOR;
              FN_NOR:          a = ALU_NOR;
              FN_SLT:          a = ALU_SLT;
              FN_SLTU:         a = ALU_SLTU;
              FN_SLL:          a = ALU_SLL;
              FN_SRL:          a = ALU_SRL;
              FN_SRA:          a = ALU_SRA;
              default:         a = ALU_NONE;
            endcase
          end
        endcase
      end
      OP_J:   c[CB_JUMP] = 1'b1;
      OP_JAL: begin
        c[CB_JUMP]      = 1'b1;
        c[CB_LINK]      = 1'b1;
        c[CB_REG_WRITE] = 1'b1;
      end
      OP_BEQ: begin
        c[CB_BRANCH] = 1'b1;
        a            = ALU_SUB;
      end
      OP_BNE: begin
        c[CB_BRANCH]    = 1'b1;
        c[CB_BRANCH_NE] = 1'b1;
        a               = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c[CB_REG_WRITE] = 1'b1;
        c[CB_ALU_SRC]   = 1'b1;
        c[CB_IMM_ZEXT]  = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        c[CB_LUI]       = (op == OP_LUI);
        case (op)
          OP_SLTI:  a = ALU_SLT;
          OP_SLTIU: a = ALU_SLTU;
          OP_ANDI:  a = ALU_AND;
          OP_ORI:   a = ALU_OR;
          OP_XORI:  a = ALU_XOR;
          OP_LUI:   a = ALU_LUI;
          default:  a = ALU_ADD;
        endcase
      end
      OP_LW: begin
        c[CB_REG_WRITE]  = 1'b1;
        c[CB_ALU_SRC]    = 1'b1;
        c[CB_MEM_READ]   = 1'b1;
        c[CB_MEM_TO_REG] = 1'b1;
        a                = ALU_ADD;
      end
      OP_SW: begin
        c[CB_ALU_SRC]   = 1'b1;
        c[CB_MEM_WRITE] = 1'b1;
        a               = ALU_ADD;
      end
      default: c = '0;
    endcase
    // Trapping instructions carry no datapath side effects down the pipe.
    if (|exc) begin
      c = '0;
      a = ALU_NONE;
    end
  end

  always_comb begin
    ctrl          = '0;
    ctrl[CN-1:0]  = c[CN-1:0];
    aluop         = '0;
    aluop[AN-1:0] = a_bits[AN-1:0];
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Purpose: carries decoded control down a STAGES-deep pipe and retires exceptions from the oldest stage.
// Latency: accepted instruction lands in stage k at the (k+1)th edge after acceptance.
// Backpressure: stall freezes every stage and drops in_ready; flush and exception-take empty the pipe.
module decode_ctrl_pipe
  import decode_ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W  = 12,
  parameter int ALUOP_W = 5,
  parameter int STAGES  = 3
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 instr,
  input  logic                        stall,
  input  logic                        flush,
  output logic [STAGES-1:0]           valid_q,
  output logic [STAGES*CTRL_W-1:0]    ctrl_q,
  output logic [STAGES*ALUOP_W-1:0]   aluop_q,
  output logic [STAGES*4-1:0]         exc_q,
  output logic                        exc_take
);

  typedef struct packed {
    logic               vld;
    logic [CTRL_W-1:0]  ctrl;
    logic [ALUOP_W-1:0] aluop;
    exc_t               exc;
  } stage_t;

  logic [CTRL_W-1:0]  dec_ctrl;
  logic [ALUOP_W-1:0] dec_aluop;
  exc_t               dec_exc;
  stage_t             dec_stg;
  stage_t             stg_q [STAGES];
  logic               accept;

  ctrl_field_decoder #(
    .CTRL_W  (CTRL_W),
    .ALUOP_W (ALUOP_W)
  ) u_dec (
    .instr (instr),
    .ctrl  (dec_ctrl),
    .aluop (dec_aluop),
    .exc   (dec_exc)
  );

  assign dec_stg = '{vld: 1'b1, ctrl: dec_ctrl, aluop: dec_aluop, exc: dec_exc};

  // Gating with resetn keeps both handshakes quiet while reset is held.
  assign exc_take = resetn & stg_q[STAGES-1].vld & (|stg_q[STAGES-1].exc) & ~stall & ~flush;
  assign in_ready = resetn & ~stall & ~flush & ~exc_take;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!resetn || flush || exc_take) begin
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else if (!stall) begin
      stg_q[0] <= accept ? dec_stg : '0;
      for (int k = 1; k < STAGES; k++) stg_q[k] <= stg_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_out
    assign valid_q[k]                     = stg_q[k].vld;
    assign ctrl_q[k*CTRL_W +: CTRL_W]     = stg_q[k].ctrl;
    assign aluop_q[k*ALUOP_W +: ALUOP_W]  = stg_q[k].aluop;
    assign exc_q[k*4 +: 4]                = stg_q[k].exc;
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: a stimulus thread queues expected retirements, a monitor checks them.
module tb_decode_ctrl_pipe;

  localparam int S  = 3;
  localparam int CW = 12;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   instr;
  logic          stall;
  logic          flush;
  logic [S-1:0]  valid_q;
  logic [S*CW-1:0] ctrl_q;
  logic [S*AW-1:0] aluop_q;
  logic [S*4-1:0]  exc_q;
  logic          exc_take;

  decode_ctrl_pipe #(.CTRL_W(CW), .ALUOP_W(AW), .STAGES(S)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .stall    (stall),
    .flush    (flush),
    .valid_q  (valid_q),
    .ctrl_q   (ctrl_q),
    .aluop_q  (aluop_q),
    .exc_q    (exc_q),
    .exc_take (exc_take)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [AW-1:0] aluop;
    logic [3:0]    exc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  // 0 addu,1 sub,2 lw,3 sw,4 ori,5 beq,6 lui,7 jal,8 slt,9 syscall,10 break,11 eret,12 reserved
  logic [31:0]   v_instr [13] = '{32'h00221821, 32'h00221822, 32'h8C220004, 32'hAC220004,
                                  32'h34220005, 32'h10220002, 32'h3C021234, 32'h0C000010,
                                  32'h0022182A, 32'h0000000C, 32'h0000000D, 32'h42000018,
                                  32'hFC000000};
  logic [CW-1:0] v_ctrl  [13] = '{12'h003, 12'h003, 12'h02D, 12'h014, 12'h405, 12'h040,
                                  12'h805, 12'h301, 12'h003, 12'h000, 12'h000, 12'h000, 12'h000};
  logic [AW-1:0] v_alu   [13] = '{5'd1, 5'd2, 5'd1, 5'd1, 5'd4, 5'd2, 5'd12, 5'd0, 5'd7,
                                  5'd0, 5'd0, 5'd0, 5'd0};
  logic [3:0]    v_exc   [13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                  4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input bit push);
    exp_t e;
    in_valid = 1'b1;
    instr    = v_instr[idx];
    if (push) begin
      e.ctrl  = v_ctrl[idx];
      e.aluop = v_alu[idx];
      e.exc   = v_exc[idx];
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Monitor: an instruction retires when the oldest stage is valid and the pipe moves.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1 && valid_q[S-1] === 1'b1 && stall === 1'b0 && flush === 1'b0) begin
      if (sb.size() == 0) begin
        check("retire_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("retire_ctrl",     64'(ctrl_q[(S-1)*CW +: CW]),  64'(e.ctrl));
        check("retire_aluop",    64'(aluop_q[(S-1)*AW +: AW]), 64'(e.aluop));
        check("retire_exc",      64'(exc_q[(S-1)*4 +: 4]),     64'(e.exc));
        check("retire_exc_take", 64'(exc_take),                64'(|e.exc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b1;
    instr    = 32'h00221821;
    stall    = 1'b0;
    flush    = 1'b0;
    tick();
    tick();
    check("rst_valid",    64'(valid_q),  64'd0);
    check("rst_ctrl",     64'(ctrl_q),   64'd0);
    check("rst_aluop",    64'(aluop_q),  64'd0);
    check("rst_exc",      64'(exc_q),    64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_exc_take", 64'(exc_take), 64'd0);
    in_valid = 1'b0;
    resetn   = 1'b1;
    tick();

    // Single addu walking the pipe.
    issue(0, 1'b1);
    check("stream_v1",    64'(valid_q), 64'b001);
    check("stream_ctrl1", 64'(ctrl_q),  64'h000_000_003);
    check("stream_exc1",  64'(exc_q),   64'd0);
    idle(1);
    check("stream_v2",    64'(valid_q), 64'b010);
    check("stream_exc2",  64'(exc_q),   64'd0);
    idle(1);
    check("stream_v3",    64'(valid_q), 64'b100);
    check("stream_exc3",  64'(exc_q),   64'd0);
    idle(1);
    check("stream_v4",    64'(valid_q), 64'b000);

    // Back-to-back non-trapping instructions.
    for (int i = 0; i <= 8; i++) issue(i, 1'b1);
    idle(4);
    check("vec_drained", 64'(valid_q), 64'd0);

    // Syscall with in_valid held: only the first one retires.
    in_valid = 1'b1;
    instr    = v_instr[9];
    sb.push_back('{ctrl: v_ctrl[9], aluop: v_alu[9], exc: v_exc[9]});
    tick();
    check("sys_take_e1", 64'(exc_take), 64'd0);
    tick();
    check("sys_take_e2", 64'(exc_take), 64'd0);
    tick();
    check("sys_valid_e3", 64'(valid_q),   64'b111);
    check("sys_exc2_e3",  64'(exc_q[11:8]), 64'b0001);
    check("sys_take_e3",  64'(exc_take),  64'd1);
    check("sys_ready_e3", 64'(in_ready),  64'd0);
    tick();
    check("sys_valid_e4", 64'(valid_q),  64'd0);
    check("sys_take_e4",  64'(exc_take), 64'd0);
    idle(2);

    // Break alone.
    issue(10, 1'b1);
    idle(4);
    check("brk_drained", 64'(valid_q), 64'd0);

    // Stall mid-stream: state frozen, sw offered during stall is not taken.
    issue(0, 1'b1);
    issue(2, 1'b1);
    stall    = 1'b1;
    in_valid = 1'b1;
    instr    = v_instr[3];
    #1;
    check("stall_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("stall_valid", 64'(valid_q), 64'b011);
      check("stall_ctrl",  64'(ctrl_q),  64'h000_003_02D);
      check("stall_aluop", 64'(aluop_q), {49'd0, 5'd0, 5'd1, 5'd1});
      check("stall_exc",   64'(exc_q),   64'd0);
      check("stall_ready_held", 64'(in_ready), 64'd0);
    end
    stall = 1'b0;
    issue(3, 1'b1);
    issue(4, 1'b1);
    idle(4);
    check("stall_drained", 64'(valid_q), 64'd0);

    // Stall coinciding with a pending exception: taken on the first unstalled cycle.
    issue(9, 1'b1);
    idle(2);
    stall = 1'b1;
    #1;
    check("stx_take_stalled", 64'(exc_take), 64'd0);
    tick();
    check("stx_valid_held", 64'(valid_q),  64'b100);
    check("stx_take_held",  64'(exc_take), 64'd0);
    stall = 1'b0;
    #1;
    check("stx_take_free",  64'(exc_take), 64'd1);
    tick();
    check("stx_valid_done", 64'(valid_q), 64'd0);

    // Flush beats stall and a stage-2 syscall.
    issue(9, 1'b0);
    idle(2);
    stall    = 1'b1;
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = v_instr[0];
    #1;
    check("flush_take",  64'(exc_take), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd0);
    tick();
    check("flush_valid", 64'(valid_q), 64'd0);
    check("flush_ctrl",  64'(ctrl_q),  64'd0);
    check("flush_exc",   64'(exc_q),   64'd0);
    stall = 1'b0;
    flush = 1'b0;
    idle(1);

    // Reserved opcode followed by eret: eret is discarded.
    issue(12, 1'b1);
    issue(11, 1'b0);
    idle(1);
    check("ri_take",  64'(exc_take), 64'd1);
    check("ri_exc_q", 64'(exc_q),    {52'd0, 4'b1000, 4'b0100, 4'b0000});
    idle(1);
    check("ri_valid_after", 64'(valid_q), 64'd0);
    idle(1);
    check("ri_eret_gone",  64'(valid_q),  64'd0);
    check("ri_take_quiet", 64'(exc_take), 64'd0);

    // Reset with three instructions in flight, one of them a syscall.
    issue(0, 1'b0);
    issue(9, 1'b0);
    issue(2, 1'b0);
    check("rst2_full", 64'(valid_q), 64'b111);
    resetn   = 1'b0;
    in_valid = 1'b1;
    instr    = v_instr[0];
    #1;
    check("rst2_ready", 64'(in_ready), 64'd0);
    check("rst2_take",  64'(exc_take), 64'd0);
    tick();
    check("rst2_valid", 64'(valid_q), 64'd0);
    check("rst2_ctrl",  64'(ctrl_q),  64'd0);
    check("rst2_aluop", 64'(aluop_q), 64'd0);
    check("rst2_exc",   64'(exc_q),   64'd0);
    resetn = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rst2_take_after", 64'(exc_take), 64'd0);
    end
    check("rst2_valid_after", 64'(valid_q), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter CTRL_W, default 12, meaning the main-control vector width.
REQ-002 SHALL have parameter ALUOP_W, default 5, meaning the ALU-control width.
REQ-003 SHALL have parameter STAGES, default 3, meaning pipeline depth (D->E, E->M, M->W); legal range 2..6.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning instr holds a fetched instruction.
REQ-007 SHALL have port in_ready, output, 1, meaning the instruction is accepted this cycle.
REQ-008 SHALL have port instr, input, 32, the MIPS instruction word.
REQ-009 SHALL have port stall, input, 1, which freezes all stages.
REQ-010 SHALL have port flush, input, 1, which kills all stages.
REQ-011 SHALL have port valid_q, output, STAGES, the per-stage valid bits; bit 0 is the youngest stage.
REQ-012 SHALL have port ctrl_q, output, STAGES*CTRL_W, the per-stage main control; stage k occupies slice k.
REQ-013 SHALL have port aluop_q, output, STAGES*ALUOP_W, the per-stage ALU control.
REQ-014 SHALL have port exc_q, output, STAGES*4, the per-stage exception bits {ri, eret, brk, sys}.
REQ-015 SHALL have port exc_take, output, 1, a pulse raised when the oldest stage commits an exception.

Function
REQ-016 SHALL decode instr combinationally to ctrl, aluop, sys (op=0, funct=0x0C), brk (op=0, funct=0x0D), eret (instr=0x42000018) and ri (opcode/funct not in the legal table).
REQ-017 SHALL drive in_ready = ~stall & ~flush & ~exc_take.
REQ-018 SHALL load stage 0 with the decoded fields and valid=1 when in_valid & in_ready; on any other non-stalled cycle it SHALL load a bubble instead.
REQ-019 On a non-stalled cycle, each stage k>0 SHALL take the contents of stage k-1.
REQ-020 Latency: an instruction accepted at edge N SHALL appear in stage k after edge N+1+k, with no stalls.
REQ-021 A bubble SHALL have valid=0 and ctrl, aluop and exc all zero; this SHALL hold for every invalid stage at every cycle.
REQ-022 When stall=1 and flush=0, all stages SHALL hold their contents and no instruction SHALL be accepted.
REQ-023 flush=1 SHALL turn all stages into bubbles at the next edge; flush takes priority over stall and exc_take.
REQ-024 exc_take SHALL equal valid_q[STAGES-1] & |exc_q[last] & ~stall & ~flush.
REQ-025 When exc_take=1, the next edge SHALL turn all stages into bubbles; the excepting instruction retires and younger instructions are discarded.
REQ-026 Several excepting instructions in flight SHALL be taken one at a time, oldest first; younger ones are removed by REQ-025.
REQ-027 When stall and exc_take conditions coincide, the stall SHALL win and the exception SHALL be taken on the first unstalled cycle.

Reset
REQ-028 With resetn=0 at an edge, all valid_q, ctrl_q, aluop_q and exc_q bits SHALL go to 0.
REQ-029 in_ready and exc_take SHALL be 0 during reset, regardless of any instructions in flight.

Structure
REQ-030 A shared package SHALL hold the opcode/funct constants, the ERET encoding, the exception-bit indices and the legal-instruction table.
REQ-031 Decoding SHALL live in one sub-module, ctrl_field_decoder, which is purely combinational; decode_ctrl_pipe SHALL hold only the stage registers and the sequencing logic.

Verification
REQ-032 Stream test: reset, then in_valid=1 with instr=0x00221821 (addu) for 1 cycle -> valid_q=001, 010, 100 on the next three edges, with exc_q all zero throughout.
REQ-033 Syscall test: instr=0x0000000C -> exc_q stage2 = 0001 on edge 3; exc_take=1 for exactly that cycle; with in_valid held, all stages are empty on edge 4.
REQ-034 Stall test: stall=1 for 2 cycles mid-stream -> valid_q, ctrl_q and exc_q stay unchanged and in_ready=0; the stream resumes without loss or duplication.
REQ-035 Flush test: flush=1 together with stall=1 and a stage-2 syscall -> exc_take=0 and all stages are bubbles at the next edge.
REQ-036 Reserved test: instr=0xFC000000 (op 0x3F) -> ri bit set; exc_take fires 3 cycles later; a following eret (0x42000018) is discarded.
REQ-037 Reset test: resetn=0 for 1 cycle with 3 instructions in flight -> all outputs are 0 at the next edge, and exc_take never pulses.
